pattern_scan_ctrl: RTL and testbench



---
 rtl/pattern_scan_pkg.sv | 20 ++
 rtl/pattern_scan_ctrl_nibble_match.sv | 14 +
 rtl/pattern_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_scan_pkg.sv
// Purpose: shared types and constants for the pattern_scan_ctrl block.
//   state_t   : controller FSM states
//   WIN_W     : sliding window width
//   PATTERN   : nibble the comparator looks for
//   PAD_CONST : shared zero constant used for tied-off outputs
package pattern_scan_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned WIN_W = 4;

   localparam logic [WIN_W-1:0] PATTERN = 4'b1010;

   localparam logic [5:0] PAD_CONST = 6'b000000;

endpackage

// File: rtl/pattern_scan_ctrl_nibble_match.sv
// Purpose: combinational 4-bit comparator against PATTERN.
// Ports:
//   win   in  WIN_W  window value to compare
//   hit_c out 1      high when win equals PATTERN (combinational)
module nibble_match
   import pattern_scan_pkg::*;
(
   input  logic [WIN_W-1:0] win,
   output logic             hit_c
);

   assign hit_c = (win == PATTERN);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Purpose: sequencing controller that accepts a serial bit stream under a
//   valid/ready handshake, slides a 4-bit window over it and counts matches
//   of the nibble comparator over a frame of FRAME_BITS accepted bits.
// Optional feature macro: PATTERN_SCAN_FIRSTPOS_EN (first-match capture).
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      synchronous active-high reset
//   start        in  1      begin a frame (sampled only in IDLE)
//   bit_in       in  1      serial data bit
//   bit_valid    in  1      bit_in valid this cycle
//   bit_ready    out 1      controller accepts a bit this cycle (combinational)
//   busy         out 1      frame in progress (combinational)
//   done         out 1      one-cycle pulse, frame complete
//   match_pulse  out 1      one-cycle pulse, window matched on last accepted bit
//   match_count  out CNT_W  saturating match count for current/last frame
//   first_hit    out 1      at least one match this frame (feature, else 0)
//   first_pos    out IDX_W  index of first matching bit (feature, else 0)
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned OVERLAP    = 1,
   parameter int unsigned CNT_W      = $clog2(FRAME_BITS + 1),
   parameter int unsigned IDX_W      = $clog2(FRAME_BITS)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic             busy,
   output logic             done,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             first_hit,
   output logic [IDX_W-1:0] first_pos
);

   localparam int unsigned       FILL_W  = 3;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_BITS - 1);

   state_t              state;
   state_t              state_nx;
   logic [WIN_W-1:0]    win;
   logic [WIN_W-1:0]    win_nx;
   logic [FILL_W-1:0]   fill;
   logic [FILL_W-1:0]   fill_nx;
   logic [IDX_W-1:0]    idx;
   logic                accept;
   logic                hit;
   logic                match;
   logic                is_last;
   logic                frame_start;

   assign accept      = bit_valid && bit_ready;
   assign win_nx      = {win[WIN_W-2:0], bit_in};
   assign is_last     = (idx == IDX_LAST);
   assign frame_start = (state == IDLE) && start;

   // Comparator sees the window as it will be after this bit shifts in
   nibble_match u_nibble_match (
      .win   (win_nx),
      .hit_c (hit)
   );

   // Only a full window (4 valid bits after the shift) may count as a match
   assign match = accept && hit && (fill >= FILL_W'(3));

   // Window fill bookkeeping; non-overlap mode restarts the fill after a hit
   always_comb begin
      fill_nx = fill;
      if (match && (OVERLAP == 0)) begin
         fill_nx = '0;
      end else if (fill < FILL_W'(4)) begin
         fill_nx = fill + FILL_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_nx  = state;
      bit_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            bit_ready = 1'b1;
            busy      = 1'b1;
            if (bit_valid && is_last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Datapath: window, fill, index, count and registered pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         win         <= '0;
         fill        <= '0;
         idx         <= '0;
         match_count <= '0;
         match_pulse <= 1'b0;
         done        <= 1'b0;
      end else begin
         match_pulse <= match;
         // Registered on the last accept so it lines up with the DONE state
         done        <= accept && is_last;
         if (frame_start) begin
            win         <= '0;
            fill        <= '0;
            idx         <= '0;
            match_count <= '0;
         end else if (accept) begin
            win  <= win_nx;
            fill <= fill_nx;
            idx  <= idx + IDX_W'(1);
            if (match && (match_count != CNT_MAX)) begin
               match_count <= match_count + CNT_W'(1);
            end
         end
      end
   end

`ifdef PATTERN_SCAN_FIRSTPOS_EN
   // Capture index of the first match in the frame
   always_ff @(posedge clk) begin
      if (rst) begin
         first_hit <= 1'b0;
         first_pos <= '0;
      end else if (frame_start) begin
         first_hit <= 1'b0;
         first_pos <= '0;
      end else if (match && !first_hit) begin
         first_hit <= 1'b1;
         first_pos <= idx;
      end
   end
`else
   assign first_hit = PAD_CONST[0];
   assign first_pos = IDX_W'(PAD_CONST);
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Purpose: self-checking bench for pattern_scan_ctrl. Three instances share
//   the stimulus: overlapping, non-overlapping and a 2-bit saturating counter.
//   Expectations come from a frame-level model that scans the stream for the
//   pattern directly.
module tb_pattern_scan_ctrl;

   localparam int unsigned FB    = 16;
   localparam int unsigned CW    = $clog2(FB + 1);
   localparam int unsigned IW    = $clog2(FB);
   localparam int unsigned CW_S  = 2;

   logic clk;
   logic rst;
   logic start;
   logic bit_in;
   logic bit_valid;

   logic          ready_ov, busy_ov, done_ov, mp_ov, fh_ov;
   logic [CW-1:0] cnt_ov;
   logic [IW-1:0] fp_ov;
   logic          ready_no, busy_no, done_no, mp_no, fh_no;
   logic [CW-1:0] cnt_no;
   logic [IW-1:0] fp_no;
   logic            ready_sa, busy_sa, done_sa, mp_sa, fh_sa;
   logic [CW_S-1:0] cnt_sa;
   logic [IW-1:0]   fp_sa;

   int compared;
   int mismatched;

   logic b[FB];
   bit   exp_ov[FB];
   bit   exp_no[FB];
   int   n_ov;
   int   n_no;
   int   first_idx;

   pattern_scan_ctrl #(.FRAME_BITS(FB), .OVERLAP(1)) u_ov (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(ready_ov), .busy(busy_ov), .done(done_ov), .match_pulse(mp_ov),
      .match_count(cnt_ov), .first_hit(fh_ov), .first_pos(fp_ov)
   );

   pattern_scan_ctrl #(.FRAME_BITS(FB), .OVERLAP(0)) u_no (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(ready_no), .busy(busy_no), .done(done_no), .match_pulse(mp_no),
      .match_count(cnt_no), .first_hit(fh_no), .first_pos(fp_no)
   );

   pattern_scan_ctrl #(.FRAME_BITS(FB), .OVERLAP(1), .CNT_W(CW_S)) u_sa (
      .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(ready_sa), .busy(busy_sa), .done(done_sa), .match_pulse(mp_sa),
      .match_count(cnt_sa), .first_hit(fh_sa), .first_pos(fp_sa)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Frame-level reference: scan bit stream (index 0 = MSB of s) for 1010
   task automatic build_model(input logic [15:0] s);
      int next_free;
      logic [3:0] w;
      logic [3:0] pat;
      pat = 4'b1010;
      n_ov = 0;
      n_no = 0;
      first_idx = -1;
      next_free = 0;
      for (int i = 0; i < 16; i++) begin
         b[i]      = s[15-i];
         exp_ov[i] = 1'b0;
         exp_no[i] = 1'b0;
      end
      for (int i = 3; i < 16; i++) begin
         w = {b[i-3], b[i-2], b[i-1], b[i]};
         if (w == pat) begin
            exp_ov[i] = 1'b1;
            n_ov++;
            if (first_idx < 0) first_idx = i;
            if (i - 3 >= next_free) begin
               exp_no[i] = 1'b1;
               n_no++;
               next_free = i + 1;
            end
         end
      end
   endtask

   task automatic check_first(input string tag);
`ifdef PATTERN_SCAN_FIRSTPOS_EN
      check({tag, "_fh"}, 32'(fh_ov), (first_idx >= 0) ? 32'd1 : 32'd0);
      check({tag, "_fp"}, 32'(fp_ov), (first_idx >= 0) ? 32'(first_idx) : 32'd0);
      check({tag, "_fh_no"}, 32'(fh_no), (first_idx >= 0) ? 32'd1 : 32'd0);
`else
      check({tag, "_fh"}, 32'(fh_ov), 32'd0);
      check({tag, "_fp"}, 32'(fp_ov), 32'd0);
      check({tag, "_fh_no"}, 32'(fh_no), 32'd0);
`endif
   endtask

   // mode 0: continuous valid, 1: alternating valid, 2: random valid,
   // 3: random valid plus a start pulse while at bit 5
   task automatic run_frame(input string tag, input logic [15:0] s, input int mode);
      int  k;
      int  prev;
      int  cyc;
      int  sat_exp;
      bit  v;
      bit  fin;
      bit  e_ov;
      bit  e_no;
      build_model(s);
      sat_exp = (n_ov > 3) ? 3 : n_ov;
      @(negedge clk);
      start     = 1'b1;
      bit_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_start"}, 32'(busy_ov), 32'd1);
      k    = 0;
      prev = -1;
      cyc  = 0;
      fin  = 1'b0;
      while (!fin) begin
         e_ov = 1'b0;
         e_no = 1'b0;
         if (prev >= 0) begin
            e_ov = exp_ov[prev];
            e_no = exp_no[prev];
         end
         check({tag, "_mp_ov"}, 32'(mp_ov), 32'(e_ov));
         check({tag, "_mp_no"}, 32'(mp_no), 32'(e_no));
         check({tag, "_done"}, 32'(done_ov), (prev == 15) ? 32'd1 : 32'd0);
         if (prev == 15) begin
            check({tag, "_done_no"}, 32'(done_no), 32'd1);
            check({tag, "_cnt_ov"}, 32'(cnt_ov), 32'(n_ov));
            check({tag, "_cnt_no"}, 32'(cnt_no), 32'(n_no));
            check({tag, "_cnt_sat"}, 32'(cnt_sa), 32'(sat_exp));
            check({tag, "_busy_done"}, 32'(busy_ov), 32'd0);
            check({tag, "_ready_done"}, 32'(ready_ov), 32'd0);
            check_first(tag);
            fin = 1'b1;
         end else if (cyc > 200) begin
            compared++;
            mismatched++;
            $error("FAIL %s_timeout: observed %0d bits expected 16", tag, k);
            fin = 1'b1;
         end else begin
            check({tag, "_ready_run"}, 32'(ready_ov), 32'd1);
            case (mode)
               0:       v = 1'b1;
               1:       v = (cyc % 2) == 1;
               default: v = 1'($urandom_range(0, 1));
            endcase
            bit_valid = v;
            bit_in    = v ? b[k] : 1'($urandom);
            start     = (mode == 3) && (k == 5);
            @(negedge clk);
            prev = v ? k : -1;
            if (v) k++;
            cyc++;
         end
      end
      // Idle after done: inputs ignored, count holds
      start     = 1'b0;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy_ov), 32'd0);
      check({tag, "_idle_ready"}, 32'(ready_ov), 32'd0);
      check({tag, "_idle_done"}, 32'(done_ov), 32'd0);
      check({tag, "_idle_mp"}, 32'(mp_ov), 32'd0);
      check({tag, "_hold_cnt"}, 32'(cnt_ov), 32'(n_ov));
      bit_valid = 1'b0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst        = 1'b1;
      start      = 1'b0;
      bit_in     = 1'b0;
      bit_valid  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy_ov), 32'd0);
      check("rst_ready", 32'(ready_ov), 32'd0);
      check("rst_done", 32'(done_ov), 32'd0);
      check("rst_mp", 32'(mp_ov), 32'd0);
      check("rst_cnt", 32'(cnt_ov), 32'd0);
      check("rst_fh", 32'(fh_ov), 32'd0);
      check("rst_fp", 32'(fp_ov), 32'd0);
      rst       = 1'b0;
      bit_valid = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(ready_ov), 32'd0);
      check("idle_busy", 32'(busy_ov), 32'd0);
      bit_valid = 1'b0;

      run_frame("alt_cont", 16'hAAAA, 0);
      run_frame("zero_toggle", 16'h0000, 1);
      run_frame("start_ignored", 16'hAAAA, 3);
      run_frame("first_pos", 16'h0500, 0);
      run_frame("first_pos_rand", 16'h0500, 2);
      run_frame("tail_match", 16'h000A, 2);
      for (int r = 0; r < 6; r++) begin
         run_frame($sformatf("rand%0d", r), 16'($urandom), (r % 2 == 0) ? 2 : 3);
      end

      // Reset in the middle of a frame discards it
      build_model(16'hAAAA);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bit_valid = 1'b1;
         bit_in    = b[i];
         @(negedge clk);
      end
      check("pre_rst_cnt", 32'(cnt_ov), 32'd2);
      check("pre_rst_busy", 32'(busy_ov), 32'd1);
      rst    = 1'b1;
      bit_in = b[6];
      @(negedge clk);
      rst       = 1'b0;
      bit_valid = 1'b0;
      check("mid_rst_busy", 32'(busy_ov), 32'd0);
      check("mid_rst_cnt", 32'(cnt_ov), 32'd0);
      check("mid_rst_cnt_no", 32'(cnt_no), 32'd0);
      check("mid_rst_mp", 32'(mp_ov), 32'd0);
      check("mid_rst_done", 32'(done_ov), 32'd0);
      check("mid_rst_fh", 32'(fh_ov), 32'd0);
      @(negedge clk);
      check("post_rst_ready", 32'(ready_ov), 32'd0);

      // A fresh frame after the reset behaves normally
      run_frame("after_rst", 16'h5A5A, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
